// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code to note half-period decoder.
// Last-pressed key wins; releasing the sounding key silences the output.
module ps2_note_decoder #(
    parameter int unsigned PREFIX_TIMEOUT = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_valid,
    input  logic [7:0]  scan_code,
    output logic [15:0] delay,
    output logic        note_on,
    output logic        note_change,
    output logic [7:0]  cur_code
);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    localparam logic [7:0]      CODE_BRK = 8'hF0;
    localparam logic [7:0]      CODE_EXT = 8'hE0;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(PREFIX_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [15:0]     delay_q, delay_d;
    logic [7:0]      cur_q, cur_d;
    logic            note_on_q;
    logic            note_change_q;
    logic [15:0]     make_delay;

    // Every mapped note has a non-zero half-period, so zero doubles as "unmapped".
    function automatic logic [15:0] note_delay(input logic [7:0] code);
        case (code)
            8'h1A:   note_delay = 16'd23889;
            8'h1B:   note_delay = 16'd22548;
            8'h22:   note_delay = 16'd21283;
            8'h23:   note_delay = 16'd20088;
            8'h21:   note_delay = 16'd18961;
            8'h2A:   note_delay = 16'd17897;
            8'h34:   note_delay = 16'd16892;
            8'h3A:   note_delay = 16'd15944;
            8'h3B:   note_delay = 16'd15049;
            8'h41:   note_delay = 16'd14205;
            8'h42:   note_delay = 16'd13407;
            8'h49:   note_delay = 16'd12655;
            8'h15:   note_delay = 16'd47778;
            8'h1E:   note_delay = 16'd45096;
            8'h1D:   note_delay = 16'd42566;
            8'h26:   note_delay = 16'd40176;
            8'h24:   note_delay = 16'd37922;
            8'h2D:   note_delay = 16'd35794;
            8'h2E:   note_delay = 16'd33784;
            8'h3C:   note_delay = 16'd31888;
            8'h3D:   note_delay = 16'd30098;
            8'h43:   note_delay = 16'd28410;
            8'h3E:   note_delay = 16'd26814;
            8'h44:   note_delay = 16'd25310;
            default: note_delay = 16'd0;
        endcase
    endfunction

    assign make_delay = note_delay(scan_code);

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        delay_d = delay_q;
        cur_d   = cur_q;
        if (scan_valid) begin
            // A prefix byte always restarts the sequence, whatever state it lands in.
            if (scan_code == CODE_BRK) begin
                state_d = (state_q == EXT) ? EXT_BRK : BRK;
            end else if (scan_code == CODE_EXT) begin
                state_d = EXT;
            end else begin
                state_d = IDLE;
                unique case (state_q)
                    IDLE: begin
                        if (make_delay != 16'd0 && scan_code != cur_q) begin
                            delay_d = make_delay;
                            cur_d   = scan_code;
                        end
                    end
                    BRK: begin
                        if (scan_code == cur_q) begin
                            delay_d = '0;
                            cur_d   = '0;
                        end
                    end
                    EXT, EXT_BRK: begin
                    end
                endcase
            end
        end else if (state_q != IDLE) begin
            if (timer_q == TO_LAST) begin
                state_d = IDLE;
            end else begin
                timer_d = timer_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            delay_q       <= '0;
            cur_q         <= '0;
            note_on_q     <= 1'b0;
            note_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            delay_q       <= delay_d;
            cur_q         <= cur_d;
            note_on_q     <= (delay_d != 16'd0);
            note_change_q <= (delay_d != delay_q);
        end
    end

    assign delay       = delay_q;
    assign note_on     = note_on_q;
    assign note_change = note_change_q;
    assign cur_code    = cur_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Self-checking bench for ps2_note_decoder: directed scenarios plus a randomized
// byte/idle stream checked against a prefix-flag reference model.
module tb_ps2_note_decoder;

    localparam int unsigned PT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic [15:0] delay;
    logic        note_on;
    logic        note_change;
    logic [7:0]  cur_code;

    ps2_note_decoder #(
        .PREFIX_TIMEOUT(PT),
        .TO_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .delay      (delay),
        .note_on    (note_on),
        .note_change(note_change),
        .cur_code   (cur_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  key_codes [24] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h3A,
                                    8'h3B, 8'h41, 8'h42, 8'h49, 8'h15, 8'h1E, 8'h1D, 8'h26,
                                    8'h24, 8'h2D, 8'h2E, 8'h3C, 8'h3D, 8'h43, 8'h3E, 8'h44};
    int unsigned key_delays[24] = '{23889, 22548, 21283, 20088, 18961, 17897, 16892, 15944,
                                    15049, 14205, 13407, 12655, 47778, 45096, 42566, 40176,
                                    37922, 35794, 33784, 31888, 30098, 28410, 26814, 25310};
    int unsigned keymap[logic [7:0]];

    // Reference model: pending-prefix flags, idle counter, sounding key.
    logic [15:0] m_delay;
    logic [7:0]  m_cur;
    bit          m_brk, m_ext, m_chg;
    int          m_idle;
    logic [25:0] got, want;

    function automatic logic [25:0] pack(input logic [15:0] d, input logic [7:0] c, input logic nc);
        return {d, (d != 16'd0), c, nc};
    endfunction

    function void m_reset();
        m_delay = '0; m_cur = '0; m_brk = 0; m_ext = 0; m_chg = 0; m_idle = 0;
    endfunction

    function void m_byte(input logic [7:0] b);
        logic [15:0] old;
        old    = m_delay;
        m_idle = 0;
        if (b == 8'hF0) begin
            m_ext = m_ext && !m_brk;
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
            m_brk = 0;
        end else begin
            if (!m_ext) begin
                if (m_brk) begin
                    if (b == m_cur) begin m_delay = '0; m_cur = '0; end
                end else if (keymap.exists(b) && b != m_cur) begin
                    m_delay = 16'(keymap[b]);
                    m_cur   = b;
                end
            end
            m_brk = 0;
            m_ext = 0;
        end
        m_chg = (m_delay != old);
    endfunction

    function void m_tick();
        m_chg = 0;
        if (m_brk || m_ext) begin
            m_idle++;
            if (m_idle >= PT) begin m_brk = 0; m_ext = 0; m_idle = 0; end
        end
    endfunction

    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        m_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            m_tick();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        scan_valid = 1'b0;
        scan_code  = '0;
        do_reset(3);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd0, 8'h00, 1'b0)) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", got, pack(16'd0, 8'h00, 1'b0));
        end
    endtask

    task automatic test_make();
        send(8'h1A);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd23889, 8'h1A, 1'b1)) begin
            n_bad++; $display("FAIL make_1A: got %h want %h", got, pack(16'd23889, 8'h1A, 1'b1));
        end
        idle(1);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd23889, 8'h1A, 1'b0)) begin
            n_bad++; $display("FAIL pulse_width: got %h want %h", got, pack(16'd23889, 8'h1A, 1'b0));
        end
    endtask

    task automatic test_priority();
        send(8'h15);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd47778, 8'h15, 1'b1)) begin
            n_bad++; $display("FAIL last_wins: got %h want %h", got, pack(16'd47778, 8'h15, 1'b1));
        end
        send(8'hF0); send(8'h1A);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd47778, 8'h15, 1'b0)) begin
            n_bad++; $display("FAIL break_old_ignored: got %h want %h", got, pack(16'd47778, 8'h15, 1'b0));
        end
        send(8'hF0); send(8'h15);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd0, 8'h00, 1'b1)) begin
            n_bad++; $display("FAIL break_silence: got %h want %h", got, pack(16'd0, 8'h00, 1'b1));
        end
        idle(1);
    endtask

    task automatic test_typematic();
        send(8'h1A);
        for (int i = 0; i < 5; i++) begin
            send(8'h1A);
            got = {delay, note_on, cur_code, note_change};
            n_cmp++;
            if (got !== pack(16'd23889, 8'h1A, 1'b0)) begin
                n_bad++; $display("FAIL typematic_%0d: got %h want %h", i, got, pack(16'd23889, 8'h1A, 1'b0));
            end
        end
    endtask

    task automatic test_extended();
        send(8'hE0); send(8'h1A);
        send(8'hE0); send(8'hF0); send(8'h1A);
        send(8'hE0); send(8'h15);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd23889, 8'h1A, 1'b0)) begin
            n_bad++; $display("FAIL extended_ignored: got %h want %h", got, pack(16'd23889, 8'h1A, 1'b0));
        end
        send(8'h1C);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd23889, 8'h1A, 1'b0)) begin
            n_bad++; $display("FAIL unmapped_make: got %h want %h", got, pack(16'd23889, 8'h1A, 1'b0));
        end
    endtask

    task automatic test_timeout();
        // One cycle short of the timeout: the prefix is still live, so 1A is a break.
        send(8'hF0); idle(PT - 1); send(8'h1A);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd0, 8'h00, 1'b1)) begin
            n_bad++; $display("FAIL timeout_minus1: got %h want %h", got, pack(16'd0, 8'h00, 1'b1));
        end
        send(8'hF0); idle(PT); send(8'h1A);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd23889, 8'h1A, 1'b1)) begin
            n_bad++; $display("FAIL timeout_exact: got %h want %h", got, pack(16'd23889, 8'h1A, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        send(8'hF0);
        do_reset(1);
        send(8'h1A);
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd23889, 8'h1A, 1'b1)) begin
            n_bad++; $display("FAIL reset_drops_prefix: got %h want %h", got, pack(16'd23889, 8'h1A, 1'b1));
        end
        reset      = 1'b1;
        scan_valid = 1'b1;
        scan_code  = 8'h15;
        @(posedge clk); #1;
        reset      = 1'b0;
        scan_valid = 1'b0;
        m_reset();
        got = {delay, note_on, cur_code, note_change};
        n_cmp++;
        if (got !== pack(16'd0, 8'h00, 1'b0)) begin
            n_bad++; $display("FAIL reset_dominates: got %h want %h", got, pack(16'd0, 8'h00, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        int         n;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (r == 11) begin
                r = $urandom_range(0, 3);
                n = (r == 0) ? int'(PT) - 1 : (r == 1) ? int'(PT) : $urandom_range(1, PT + 3);
                idle(n);
            end else begin
                if (r <= 4)      b = key_codes[$urandom_range(0, 23)];
                else if (r <= 6) b = 8'hF0;
                else if (r == 7) b = 8'hE0;
                else if (r == 8) b = 8'($urandom);
                else             b = (m_cur != 8'h00) ? m_cur : key_codes[$urandom_range(0, 23)];
                send(b);
            end
            want = pack(m_delay, m_cur, m_chg);
            got  = {delay, note_on, cur_code, note_change};
            n_cmp++;
            if (got !== want) begin
                n_bad++; $display("FAIL random_%0d (byte %h): got %h want %h", i, b, got, want);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 24; i++) keymap[key_codes[i]] = key_delays[i];
        m_reset();
        reset      = 1'b0;
        scan_valid = 1'b0;
        scan_code  = '0;
        test_reset();
        test_make();
        test_priority();
        test_typematic();
        test_extended();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
